// File: rtl/pong_engine.sv
// pong_engine: frame-rate Pong core with ball, player/AI paddles, scores and serve/point/over sequencing.
// Optional: define PONG_SPEEDUP_EN so that each paddle hit raises the horizontal ball speed.
module pong_engine #(
    parameter int SCREEN_W     = 640,
    parameter int SCREEN_H     = 480,
    parameter int BALL_SIZE    = 10,
    parameter int PADDLE_W     = 10,
    parameter int PADDLE_H     = 60,
    parameter int PADDLE_SPEED = 2,
    parameter int BALL_SPEED   = 2,
    parameter int AI_SPEED     = 1,
    parameter int OPP_X        = 30,
    parameter int PLAYER_X     = 610,
    parameter int WIN_SCORE    = 9,
    parameter int SERVE_FRAMES = 30,
    parameter int POS_W        = 10
) (
    input  logic             clk_div,
    input  logic             rst_n,
    input  logic             btn_up,
    input  logic             btn_down,
    input  logic             start,
    output logic [POS_W-1:0] ball_x,
    output logic [POS_W-1:0] ball_y,
    output logic [POS_W-1:0] paddle_y,
    output logic [POS_W-1:0] op_paddle_y,
    output logic [3:0]       score_p,
    output logic [3:0]       score_o,
    output logic [1:0]       state,
    output logic             hit,
    output logic             game_over
);
    typedef enum logic [1:0] {SERVE = 2'd0, PLAY = 2'd1, POINT = 2'd2, OVER = 2'd3} state_t;

    // Geometry is evaluated two bits wider than positions so sums never wrap.
    localparam int EW = POS_W + 2;
    localparam int CW = $clog2(SERVE_FRAMES + 1);
    typedef logic [EW-1:0] ext_t;

    localparam logic [POS_W-1:0] BALL_CX = POS_W'((SCREEN_W - BALL_SIZE) / 2);
    localparam logic [POS_W-1:0] BALL_CY = POS_W'((SCREEN_H - BALL_SIZE) / 2);
    localparam logic [POS_W-1:0] PAD_C   = POS_W'((SCREEN_H - PADDLE_H) / 2);
    localparam ext_t PAD_MAX  = EW'(SCREEN_H - PADDLE_H);
    localparam ext_t BY_MAX   = EW'(SCREEN_H - BALL_SIZE);
    localparam ext_t SCR_W    = EW'(SCREEN_W);
    localparam ext_t SCR_H    = EW'(SCREEN_H);
    localparam ext_t BSZ      = EW'(BALL_SIZE);
    localparam ext_t BSPD     = EW'(BALL_SPEED);
    localparam ext_t PAD_H    = EW'(PADDLE_H);
    localparam ext_t PAD_SPD  = EW'(PADDLE_SPEED);
    localparam ext_t AI_STEP  = EW'(AI_SPEED);
    localparam ext_t HALF_B   = EW'(BALL_SIZE / 2);
    localparam ext_t HALF_P   = EW'(PADDLE_H / 2);
    localparam ext_t P_FACE   = EW'(PLAYER_X);
    localparam ext_t O_FACE   = EW'(OPP_X + PADDLE_W);
    localparam logic [3:0] WIN = 4'(WIN_SCORE);

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [POS_W-1:0] ball_x_d, ball_y_d, paddle_y_d, op_paddle_y_d;
    logic [3:0]       score_p_d, score_o_d;
    logic             dir_x, dir_x_d, dir_y, dir_y_d, hit_d;
    ext_t             speed_x;
`ifdef PONG_SPEEDUP_EN
    ext_t             speed_d;
    localparam ext_t  SPD_MAX = EW'(2 * BALL_SPEED);
`else
    assign speed_x = BSPD;
`endif

    ext_t ebx, eby, epy, eoy;
    assign ebx = EW'(ball_x);
    assign eby = EW'(ball_y);
    assign epy = EW'(paddle_y);
    assign eoy = EW'(op_paddle_y);

    logic [POS_W-1:0] py_move, oy_move, bx_step, by_step;
    logic             dx_step, dy_step, p_hit, o_hit, miss_o, miss_p;

    assign p_hit = dir_x && (ebx + BSZ <= P_FACE) && (ebx + BSZ + speed_x >= P_FACE)
                   && (eby + BSZ > epy) && (eby < epy + PAD_H);
    assign o_hit = !dir_x && (ebx >= O_FACE) && (ebx <= O_FACE + speed_x)
                   && (eby + BSZ > eoy) && (eby < eoy + PAD_H);

    always_comb begin
        py_move = paddle_y;
        if (btn_up)
            py_move = (epy < PAD_SPD) ? '0 : POS_W'(epy - PAD_SPD);
        else if (btn_down)
            py_move = (epy + PAD_SPD > PAD_MAX) ? POS_W'(PAD_MAX) : POS_W'(epy + PAD_SPD);

        // The AI chases the ball centre with its own paddle centre.
        oy_move = op_paddle_y;
        if (eby + HALF_B < eoy + HALF_P)
            oy_move = (eoy < AI_STEP) ? '0 : POS_W'(eoy - AI_STEP);
        else if (eby + HALF_B > eoy + HALF_P)
            oy_move = (eoy + AI_STEP > PAD_MAX) ? POS_W'(PAD_MAX) : POS_W'(eoy + AI_STEP);

        by_step = ball_y;
        dy_step = dir_y;
        if (!dir_y) begin
            if (eby < BSPD) begin by_step = '0; dy_step = 1'b1; end
            else            by_step = POS_W'(eby - BSPD);
        end else begin
            if (eby + BSZ + BSPD > SCR_H) begin by_step = POS_W'(BY_MAX); dy_step = 1'b0; end
            else                          by_step = POS_W'(eby + BSPD);
        end

        bx_step = ball_x;
        dx_step = dir_x;
        miss_o  = 1'b0;
        miss_p  = 1'b0;
        if (dir_x) begin
            if (p_hit) begin bx_step = POS_W'(P_FACE - BSZ); dx_step = 1'b0; end
            else if (ebx + BSZ + speed_x >= SCR_W) miss_o = 1'b1;
            else bx_step = POS_W'(ebx + speed_x);
        end else begin
            if (o_hit) begin bx_step = POS_W'(O_FACE); dx_step = 1'b1; end
            else if (ebx < speed_x) miss_p = 1'b1;
            else bx_step = POS_W'(ebx - speed_x);
        end
    end

    always_comb begin
        // NOTE: every next value defaults to the held value first, so no branch can infer a latch.
        state_d       = state_q;
        cnt_d         = cnt_q;
        ball_x_d      = ball_x;
        ball_y_d      = ball_y;
        dir_x_d       = dir_x;
        dir_y_d       = dir_y;
        paddle_y_d    = paddle_y;
        op_paddle_y_d = op_paddle_y;
        score_p_d     = score_p;
        score_o_d     = score_o;
        hit_d         = 1'b0;
`ifdef PONG_SPEEDUP_EN
        speed_d       = speed_x;
`endif
        case (state_q)
            SERVE: begin
                paddle_y_d = py_move;
                if (cnt_q == CW'(SERVE_FRAMES)) state_d = PLAY;
                else                            cnt_d   = cnt_q + 1'b1;
            end
            PLAY: begin
                paddle_y_d    = py_move;
                op_paddle_y_d = oy_move;
                if (miss_o || miss_p) begin
                    state_d = POINT;
                    if (miss_o && score_o != WIN) score_o_d = score_o + 1'b1;
                    if (miss_p && score_p != WIN) score_p_d = score_p + 1'b1;
                end else begin
                    ball_x_d = bx_step;
                    dir_x_d  = dx_step;
                    ball_y_d = by_step;
                    dir_y_d  = dy_step;
                    hit_d    = p_hit || o_hit;
`ifdef PONG_SPEEDUP_EN
                    if ((p_hit || o_hit) && speed_x < SPD_MAX) speed_d = speed_x + 1'b1;
`endif
                end
            end
            POINT: begin
                paddle_y_d = py_move;
                if (score_p == WIN || score_o == WIN) begin
                    state_d = OVER;
                end else begin
                    // dir_x was left untouched by the miss, so it already points at the conceding side.
                    state_d  = SERVE;
                    ball_x_d = BALL_CX;
                    ball_y_d = BALL_CY;
                    dir_y_d  = !dir_y;
                    cnt_d    = '0;
`ifdef PONG_SPEEDUP_EN
                    speed_d  = BSPD;
`endif
                end
            end
            OVER: begin
                if (start) begin
                    state_d   = SERVE;
                    score_p_d = '0;
                    score_o_d = '0;
                    ball_x_d  = BALL_CX;
                    ball_y_d  = BALL_CY;
                    cnt_d     = '0;
`ifdef PONG_SPEEDUP_EN
                    speed_d   = BSPD;
`endif
                end
            end
            default: state_d = SERVE;
        endcase
    end

    always_ff @(posedge clk_div) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            state_q     <= SERVE;
            cnt_q       <= '0;
            ball_x      <= BALL_CX;
            ball_y      <= BALL_CY;
            dir_x       <= 1'b1;
            dir_y       <= 1'b1;
            paddle_y    <= PAD_C;
            op_paddle_y <= PAD_C;
            score_p     <= '0;
            score_o     <= '0;
            hit         <= 1'b0;
`ifdef PONG_SPEEDUP_EN
            speed_x     <= BSPD;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ball_x      <= ball_x_d;
            ball_y      <= ball_y_d;
            dir_x       <= dir_x_d;
            dir_y       <= dir_y_d;
            paddle_y    <= paddle_y_d;
            op_paddle_y <= op_paddle_y_d;
            score_p     <= score_p_d;
            score_o     <= score_o_d;
            hit         <= hit_d;
`ifdef PONG_SPEEDUP_EN
            speed_x     <= speed_d;
`endif
        end
    end

    assign state     = state_q;
    assign game_over = (state_q == OVER);

endmodule

// File: tb/tb_pong_engine.sv
// tb_pong_engine: randomized play of pong_engine checked frame by frame against a behavioural game model.
module tb_pong_engine;
    localparam int SCREEN_W = 640, SCREEN_H = 480, BALL_SIZE = 10, PADDLE_W = 10, PADDLE_H = 60;
    localparam int PADDLE_SPEED = 2, BALL_SPEED = 2, AI_SPEED = 1, OPP_X = 30, PLAYER_X = 610;
    localparam int WIN_SCORE = 9, SERVE_FRAMES = 30;

    logic       clk_div = 1'b0;
    logic       rst_n, btn_up, btn_down, start;
    logic [9:0] ball_x, ball_y, paddle_y, op_paddle_y;
    logic [3:0] score_p, score_o;
    logic [1:0] state;
    logic       hit, game_over;

    pong_engine dut (
        .clk_div(clk_div), .rst_n(rst_n), .btn_up(btn_up), .btn_down(btn_down), .start(start),
        .ball_x(ball_x), .ball_y(ball_y), .paddle_y(paddle_y), .op_paddle_y(op_paddle_y),
        .score_p(score_p), .score_o(score_o), .state(state), .hit(hit), .game_over(game_over)
    );

    always #5 clk_div = ~clk_div;

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Game model: 0 serve, 1 play, 2 point, 3 over; dx 1 = right, dy 1 = down.
    int m_state, m_cnt, m_bx, m_by, m_dx, m_dy, m_py, m_oy, m_sp, m_so, m_hit, m_spd;

    task automatic model_centre();
        m_bx = (SCREEN_W - BALL_SIZE) / 2;
        m_by = (SCREEN_H - BALL_SIZE) / 2;
    endtask

    task automatic model_reset();
        m_state = 0; m_cnt = 0; model_centre();
        m_dx = 1; m_dy = 1;
        m_py = (SCREEN_H - PADDLE_H) / 2; m_oy = m_py;
        m_sp = 0; m_so = 0; m_hit = 0; m_spd = BALL_SPEED;
    endtask

    task automatic model_step(input bit up, input bit dn, input bit st, input bit rn);
        int npy, noy, nbx, ndx, scorer, bc, pc;
        bit phit, ohit;
        if (!rn) begin
            model_reset();
            return;
        end
        npy = m_py;
        if (up)      npy = (m_py - PADDLE_SPEED < 0) ? 0 : m_py - PADDLE_SPEED;
        else if (dn) npy = (m_py + PADDLE_SPEED > SCREEN_H - PADDLE_H) ? SCREEN_H - PADDLE_H : m_py + PADDLE_SPEED;
        m_hit = 0;
        case (m_state)
            0: begin
                m_py = npy;
                if (m_cnt == SERVE_FRAMES) m_state = 1; else m_cnt++;
            end
            1: begin
                bc = m_by + BALL_SIZE / 2;
                pc = m_oy + PADDLE_H / 2;
                noy = m_oy;
                if (bc < pc)      noy = (m_oy - AI_SPEED < 0) ? 0 : m_oy - AI_SPEED;
                else if (bc > pc) noy = (m_oy + AI_SPEED > SCREEN_H - PADDLE_H) ? SCREEN_H - PADDLE_H : m_oy + AI_SPEED;
                phit = m_dx == 1 && m_bx + BALL_SIZE <= PLAYER_X && m_bx + BALL_SIZE + m_spd >= PLAYER_X
                       && m_by + BALL_SIZE > m_py && m_by < m_py + PADDLE_H;
                ohit = m_dx == 0 && m_bx >= OPP_X + PADDLE_W && m_bx - m_spd <= OPP_X + PADDLE_W
                       && m_by + BALL_SIZE > m_oy && m_by < m_oy + PADDLE_H;
                nbx = m_bx; ndx = m_dx; scorer = 0;
                if (m_dx == 1) begin
                    if (phit) begin nbx = PLAYER_X - BALL_SIZE; ndx = 0; end
                    else if (m_bx + BALL_SIZE + m_spd >= SCREEN_W) scorer = 2;
                    else nbx = m_bx + m_spd;
                end else begin
                    if (ohit) begin nbx = OPP_X + PADDLE_W; ndx = 1; end
                    else if (m_bx < m_spd) scorer = 1;
                    else nbx = m_bx - m_spd;
                end
                if (scorer != 0) begin
                    m_state = 2;
                    if (scorer == 2 && m_so < WIN_SCORE) m_so++;
                    if (scorer == 1 && m_sp < WIN_SCORE) m_sp++;
                end else begin
                    if (m_dy == 0) begin
                        if (m_by < BALL_SPEED) begin m_by = 0; m_dy = 1; end
                        else m_by = m_by - BALL_SPEED;
                    end else begin
                        if (m_by + BALL_SIZE + BALL_SPEED > SCREEN_H) begin m_by = SCREEN_H - BALL_SIZE; m_dy = 0; end
                        else m_by = m_by + BALL_SPEED;
                    end
                    m_bx = nbx; m_dx = ndx;
                    m_hit = (phit || ohit) ? 1 : 0;
`ifdef PONG_SPEEDUP_EN
                    if (m_hit == 1 && m_spd < 2 * BALL_SPEED) m_spd++;
`endif
                end
                m_py = npy; m_oy = noy;
            end
            2: begin
                m_py = npy;
                if (m_sp == WIN_SCORE || m_so == WIN_SCORE) m_state = 3;
                else begin
                    m_state = 0; model_centre(); m_dy = 1 - m_dy; m_cnt = 0; m_spd = BALL_SPEED;
                end
            end
            default: begin
                if (st) begin
                    m_sp = 0; m_so = 0; model_centre(); m_state = 0; m_cnt = 0; m_spd = BALL_SPEED;
                end
            end
        endcase
    endtask

    task automatic compare_all();
        check("state", int'(state), m_state);
        check("ball_x", int'(ball_x), m_bx);
        check("ball_y", int'(ball_y), m_by);
        check("paddle_y", int'(paddle_y), m_py);
        check("op_paddle_y", int'(op_paddle_y), m_oy);
        check("score_p", int'(score_p), m_sp);
        check("score_o", int'(score_o), m_so);
        check("hit", int'(hit), m_hit);
        check("game_over", int'(game_over), (m_state == 3) ? 1 : 0);
`ifdef PONG_SPEEDUP_EN
        check("speed_x", int'(dut.speed_x), m_spd);
`endif
    endtask

    task automatic frame(input bit up, input bit dn, input bit st, input bit rn);
        btn_up = up; btn_down = dn; start = st; rst_n = rn;
        @(posedge clk_div);
        model_step(up, dn, st, rn);
        #1;
        compare_all();
    endtask

    initial begin
        int  skill, games, prev, hits_seen;
        bit  up, dn, st, rn;
        btn_up = 0; btn_down = 0; start = 0; rst_n = 0;
        model_reset();
        repeat (2) frame(0, 0, 0, 0);
        check("rst_state", int'(state), 0);
        check("rst_ball_x", int'(ball_x), 315);
        check("rst_ball_y", int'(ball_y), 235);
        check("rst_paddles", int'(paddle_y) + int'(op_paddle_y), 420);
        check("rst_hit", int'(hit), 0);

        for (int i = 0; i < 30; i++) begin
            frame(0, 0, 0, 1);
            check("serve_hold", int'(state), 0);
        end
        frame(0, 0, 0, 1);
        check("serve_to_play", int'(state), 1);
        frame(0, 0, 0, 1);
        check("first_move_x", int'(ball_x), 317);
        check("first_move_y", int'(ball_y), 237);

        frame(0, 0, 0, 0);
        for (int i = 0; i < 110; i++) frame(1, 0, 0, 1);
        check("paddle_top_sat", int'(paddle_y), 0);
        for (int i = 0; i < 20; i++) frame(0, 1, 0, 1);
        check("paddle_down", int'(paddle_y), 40);
        for (int i = 0; i < 5; i++) frame(1, 1, 0, 1);
        check("both_btn_up_wins", int'(paddle_y), 30);

        skill = 80; games = 0; hits_seen = 0;
        for (int f = 0; f < 60000 && games < 2; f++) begin
            up = 0; dn = 0; st = 0; rn = 1;
            if ($urandom_range(99) < skill) begin
                if (m_by + BALL_SIZE / 2 < m_py + PADDLE_H / 2 - 8)      up = 1;
                else if (m_by + BALL_SIZE / 2 > m_py + PADDLE_H / 2 + 8) dn = 1;
            end else begin
                up = 1'($urandom_range(1));
                dn = 1'($urandom_range(1));
            end
            if (m_state == 3) st = ($urandom_range(7) == 0);
            if (f == 700 || $urandom_range(19999) == 0) rn = 0;
            prev = m_state;
            frame(up, dn, st, rn);
            if (m_hit == 1) hits_seen++;
            if (m_state == 3 && prev != 3) games++;
            if (m_state == 0 && prev == 2) skill = $urandom_range(100, 40);
        end
        check("games_completed", (games >= 2) ? 1 : 0, 1);
        check("hits_observed", (hits_seen > 0) ? 1 : 0, 1);

        frame(0, 0, 0, 0);
        check("late_reset_state", int'(state), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
